dptr_seq: RTL and testbench
===========================

Name: dptr_seq

Overview:
- Multicycle sequencer for the R-type datapath (DPTR).
- Accepts one 32-bit R-type instruction at a time over a valid/ready handshake and checks its fields.
- Steps each instruction through DECODE, EXEC and WB: drives the datapath instruction bus, generates the ALU op, register-file write enable and write address, then captures the datapath zero flag (TRZF).
- Sits between the instruction source (fetch stub or testbench) and DPTR; keeps a retired-instruction count and flags illegal encodings.

Parameters:
- EXEC_CYCLES, 1: cycles held in EXEC for datapath settle; legal range 1..15.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  source has an instruction on instruccion_in.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instruccion_in  in  32  incoming instruction word.
- dp_instruccion  out  32  instruction word driven to DPTR.
- alu_op  out  3  decoded ALU operation.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_wa  out  5  register-file write address (rd field).
- dp_trzf  in  1  zero flag from DPTR.
- zf  out  1  zero flag latched at WB of last retired instruction.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when an instruction is rejected.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset values:
  - All outputs 0 except instr_ready=1.
  - State=IDLE; dp_instruccion=0; alu_op=AND code (000); retired=0; zf=0.
- Reset mid-operation: state returns to IDLE the following edge, the in-flight instruction is discarded, and no rf_we or done is issued.
- Field split:
  - op [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
- States and transitions:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, capture the word into an internal register and go to DECODE. Without valid, stay.
  - DECODE: legal when op==0, shamt==0 and funct is one of 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
    - Legal: set dp_instruccion=captured word, set alu_op, go to EXEC.
    - Illegal: go to ERR; dp_instruccion is left unchanged.
  - EXEC: hold dp_instruccion and alu_op. A down-counter is loaded with EXEC_CYCLES-1 on entry; leave for WB when it reaches 0. EXEC_CYCLES=1 means one EXEC cycle.
  - WB:
    - rf_we=1 only if rd!=0 (writes to $0 are suppressed); rf_wa=rd.
    - zf<=dp_trzf, done=1, retired increments and saturates at all-ones.
    - Next state IDLE.
  - ERR: illegal=1 for one cycle; no rf_we, no counter change, zf unchanged. Next state IDLE.
- Output hold rules:
  - dp_instruccion and alu_op hold their last values in IDLE; they are not cleared.
  - rf_wa is valid only while rf_we=1; it holds otherwise.
- ALU op codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Latency:
  - Accept edge to done pulse is 2+EXEC_CYCLES cycles.
  - Throughput is one instruction per 3+EXEC_CYCLES cycles, because the return to IDLE costs one cycle.
- Handshake:
  - instruccion_in is sampled only on the accepting edge; changes while busy are ignored.
  - instr_valid may stay high across instructions; the next word is taken on the first IDLE cycle.

Decomposition:
- Package dptr_pkg:
  - state enum {IDLE, DECODE, EXEC, WB, ERR}.
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - ALU op constants.
  - field-slice localparams.
- One natural sub-module: dptr_decode (combinational legality check and funct-to-alu_op mapping).
- The FSM, counters and registers stay in dptr_seq.

Test Plan:
- Reset then 0x00A60820 (ADD rs=5 rt=6 rd=1), EXEC_CYCLES=1 -> at accept+3 cycles: done=1, rf_we=1, rf_wa=1, alu_op=010, retired=1.
- 0x002A0020 (ADD rd=0) -> done=1, rf_we stays 0, retired increments; then 0x00281022 (SUB rs=1 rt=8 rd=2) -> alu_op=110, rf_wa=2.
- 0x00BD982A (SLT rd=19) with dp_trzf forced 1 during WB -> zf=1, alu_op=111; next instruction with dp_trzf=0 -> zf=0.
- Illegal funct 0x00A60827 (NOR), then op!=0 word 0x20A60820, then shamt=1 ADD 0x00A60860 -> each gives one illegal pulse, no rf_we, retired unchanged, instr_ready back high 2 cycles after accept.
- instr_valid held high with four back-to-back legal words, EXEC_CYCLES=3 -> done pulses every 6 cycles, instr_ready=0 while busy, retired=4.
- rst asserted during EXEC -> next cycle state IDLE, instr_ready=1, retired=0, no done or rf_we; a CNT_W=2 build with 5 instructions -> retired saturates at 3.

Source files
------------

// File: rtl/dptr_seq_pkg.sv
// Shared types and constants for the R-type datapath sequencer:
// FSM state encoding, funct codes, ALU op codes and instruction field positions.
package dptr_pkg;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

endpackage

// File: rtl/dptr_seq_if.sv
// Bundle between the instruction source / datapath and the sequencer.
// master = source and datapath side, slave = sequencer side.
interface dptr_seq_if #(parameter int CNT_W = 16) ();
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instruccion_in;
  logic [31:0]      dp_instruccion;
  logic [2:0]       alu_op;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic             dp_trzf;
  logic             zf;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output instr_valid, instruccion_in, dp_trzf,
    input  instr_ready, dp_instruccion, alu_op, rf_we, rf_wa, zf, busy, done, illegal, retired
  );

  modport slave (
    input  instr_valid, instruccion_in, dp_trzf,
    output instr_ready, dp_instruccion, alu_op, rf_we, rf_wa, zf, busy, done, illegal, retired
  );
endinterface

// File: rtl/dptr_decode.sv
// Combinational R-type legality check and funct-to-ALU-op mapping.
// Zero latency; no handshake of its own.
module dptr_decode
  import dptr_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] shamt,
  input  logic [5:0] funct,
  output logic       legal,
  output logic [2:0] alu_op
);

  logic funct_ok;

  always_comb begin
    funct_ok = 1'b1;
    alu_op   = ALU_AND;
    case (funct)
      F_ADD:   alu_op = ALU_ADD;
      F_SUB:   alu_op = ALU_SUB;
      F_AND:   alu_op = ALU_AND;
      F_OR:    alu_op = ALU_OR;
      F_SLT:   alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
    legal = funct_ok && (op == 6'd0) && (shamt == 5'd0);
  end

endmodule

// File: rtl/dptr_seq.sv
// Multicycle DECODE/EXEC/WB sequencer for the R-type datapath; accept-to-done is 2+EXEC_CYCLES
// cycles, one instruction per 3+EXEC_CYCLES; instr_ready is high only in IDLE.
module dptr_seq
  import dptr_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input logic       clk,
  input logic       rst,
  dptr_seq_if.slave bus
);

  state_t           state;
  logic [31:0]      ir;
  logic [3:0]       ex_cnt;
  logic             ready;
  logic             busy;
  logic [31:0]      dp_instr;
  logic [2:0]       alu_op;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic             zf;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  logic             dec_legal;
  logic [2:0]       dec_op;
  logic [4:0]       rd;

  assign rd = ir[RD_HI:RD_LO];

  dptr_decode u_decode (
    .op     (ir[OP_HI:OP_LO]),
    .shamt  (ir[SH_HI:SH_LO]),
    .funct  (ir[FN_HI:FN_LO]),
    .legal  (dec_legal),
    .alu_op (dec_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ir       <= '0;
      ex_cnt   <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      dp_instr <= '0;
      alu_op   <= ALU_AND;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      zf       <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instruccion_in;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            dp_instr <= ir;
            alu_op   <= dec_op;
            ex_cnt   <= 4'(EXEC_CYCLES - 1);
            state    <= EXEC;
          end else begin
            state <= ERR;
          end
        end
        EXEC: begin
          if (ex_cnt == 4'd0) state <= WB;
          else                ex_cnt <= ex_cnt - 4'd1;
        end
        WB: begin
          // Writes to register 0 are dropped; rf_wa keeps its last real target.
          if (rd != 5'd0) begin
            rf_we <= 1'b1;
            rf_wa <= rd;
          end
          zf    <= bus.dp_trzf;
          done  <= 1'b1;
          if (retired != '1) retired <= retired + 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          illegal <= 1'b1;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready    = ready;
  assign bus.busy           = busy;
  assign bus.dp_instruccion = dp_instr;
  assign bus.alu_op         = alu_op;
  assign bus.rf_we          = rf_we;
  assign bus.rf_wa          = rf_wa;
  assign bus.zf             = zf;
  assign bus.done           = done;
  assign bus.illegal        = illegal;
  assign bus.retired        = retired;

endmodule

// File: tb/tb_dptr_seq.sv
// Directed bench for dptr_seq: three builds (EXEC_CYCLES=1, EXEC_CYCLES=3, CNT_W=2)
// share one stimulus set, steered by sel.
module tb_dptr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] instr = '0;
  logic        trzf = 1'b0;
  int          sel = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dptr_seq_if #(.CNT_W(16)) ifa ();
  dptr_seq_if #(.CNT_W(16)) ifb ();
  dptr_seq_if #(.CNT_W(2))  ifc ();

  dptr_seq #(.EXEC_CYCLES(1), .CNT_W(16)) ua (.clk(clk), .rst(rst), .bus(ifa.slave));
  dptr_seq #(.EXEC_CYCLES(3), .CNT_W(16)) ub (.clk(clk), .rst(rst), .bus(ifb.slave));
  dptr_seq #(.EXEC_CYCLES(1), .CNT_W(2))  uc (.clk(clk), .rst(rst), .bus(ifc.slave));

  assign ifa.instr_valid = valid && (sel == 0);
  assign ifb.instr_valid = valid && (sel == 1);
  assign ifc.instr_valid = valid && (sel == 2);
  assign ifa.instruccion_in = instr;
  assign ifb.instruccion_in = instr;
  assign ifc.instruccion_in = instr;
  assign ifa.dp_trzf = trzf;
  assign ifb.dp_trzf = trzf;
  assign ifc.dp_trzf = trzf;

  logic        o_ready, o_busy, o_done, o_ill, o_we, o_zf;
  logic [4:0]  o_wa;
  logic [2:0]  o_alu;
  logic [31:0] o_dp;
  logic [15:0] o_ret;

  always_comb begin
    o_ready = ifa.instr_ready; o_busy = ifa.busy; o_done = ifa.done; o_ill = ifa.illegal;
    o_we = ifa.rf_we; o_zf = ifa.zf; o_wa = ifa.rf_wa; o_alu = ifa.alu_op;
    o_dp = ifa.dp_instruccion; o_ret = ifa.retired;
    if (sel == 1) begin
      o_ready = ifb.instr_ready; o_busy = ifb.busy; o_done = ifb.done; o_ill = ifb.illegal;
      o_we = ifb.rf_we; o_zf = ifb.zf; o_wa = ifb.rf_wa; o_alu = ifb.alu_op;
      o_dp = ifb.dp_instruccion; o_ret = ifb.retired;
    end else if (sel == 2) begin
      o_ready = ifc.instr_ready; o_busy = ifc.busy; o_done = ifc.done; o_ill = ifc.illegal;
      o_we = ifc.rf_we; o_zf = ifc.zf; o_wa = ifc.rf_wa; o_alu = ifc.alu_op;
      o_dp = ifc.dp_instruccion; o_ret = {14'd0, ifc.retired};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for exactly one accepting edge; returns 1ns after that edge.
  task automatic issue(input logic [31:0] w);
    valid = 1'b1;
    instr = w;
    tick();
    valid = 1'b0;
  endtask

  // Legal instruction with EXEC_CYCLES=1: done lands 3 edges after accept.
  task automatic run_legal(input logic [31:0] w);
    issue(w);
    chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
    tick();
    tick();
    chk("no_done_in_wb", {31'd0, o_done}, 32'd0);
    tick();
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] w, input logic [31:0] prev_dp,
                             input logic [15:0] ret_exp);
    issue(w);
    chk({tag, "_ready_low"}, {31'd0, o_ready}, 32'd0);
    tick();
    chk({tag, "_no_ill_yet"}, {31'd0, o_ill}, 32'd0);
    tick();
    chk({tag, "_illegal"}, {31'd0, o_ill}, 32'd1);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    chk({tag, "_no_we"}, {31'd0, o_we}, 32'd0);
    chk({tag, "_no_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_retired"}, {16'd0, o_ret}, {16'd0, ret_exp});
    chk({tag, "_dp_kept"}, o_dp, prev_dp);
    tick();
    chk({tag, "_ill_pulse"}, {31'd0, o_ill}, 32'd0);
  endtask

  logic [31:0] words [4];
  logic [2:0]  ops   [4];

  initial begin
    words[0] = 32'h00A60820; ops[0] = 3'b010;
    words[1] = 32'h00281022; ops[1] = 3'b110;
    words[2] = 32'h00BD982A; ops[2] = 3'b111;
    words[3] = 32'h002A0020; ops[3] = 3'b010;

    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done_ill_we", {29'd0, o_done, o_ill, o_we}, 32'd0);
      chk("rst_dp", o_dp, 32'd0);
      chk("rst_alu_zf_wa", {23'd0, o_alu, o_zf, o_wa}, 32'd0);
      chk("rst_retired", {16'd0, o_ret}, 32'd0);
    end
    sel = 0;
    #0;

    run_legal(32'h00A60820);
    chk("add_done", {31'd0, o_done}, 32'd1);
    chk("add_we", {31'd0, o_we}, 32'd1);
    chk("add_wa", {27'd0, o_wa}, 32'd1);
    chk("add_alu", {29'd0, o_alu}, 32'd2);
    chk("add_ret", {16'd0, o_ret}, 32'd1);
    chk("add_ready", {31'd0, o_ready}, 32'd1);
    chk("add_dp", o_dp, 32'h00A60820);
    tick();
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
    chk("we_one_cycle", {31'd0, o_we}, 32'd0);

    run_legal(32'h002A0020);
    chk("rd0_done", {31'd0, o_done}, 32'd1);
    chk("rd0_no_we", {31'd0, o_we}, 32'd0);
    chk("rd0_wa_held", {27'd0, o_wa}, 32'd1);
    chk("rd0_ret", {16'd0, o_ret}, 32'd2);

    run_legal(32'h00281022);
    chk("sub_alu", {29'd0, o_alu}, 32'd6);
    chk("sub_wa", {27'd0, o_wa}, 32'd2);
    chk("sub_we", {31'd0, o_we}, 32'd1);
    chk("sub_ret", {16'd0, o_ret}, 32'd3);

    trzf = 1'b1;
    run_legal(32'h00BD982A);
    chk("slt_zf", {31'd0, o_zf}, 32'd1);
    chk("slt_alu", {29'd0, o_alu}, 32'd7);
    chk("slt_wa", {27'd0, o_wa}, 32'd19);
    trzf = 1'b0;
    run_legal(32'h00A60820);
    chk("zf_cleared", {31'd0, o_zf}, 32'd0);
    chk("ret5", {16'd0, o_ret}, 32'd5);

    run_illegal("nor", 32'h00A60827, 32'h00A60820, 16'd5);
    run_illegal("op_nz", 32'h20A60820, 32'h00A60820, 16'd5);
    run_illegal("shamt", 32'h00A60860, 32'h00A60820, 16'd5);
    chk("zf_after_ill", {31'd0, o_zf}, 32'd0);

    // Reset while in EXEC discards the instruction.
    trzf = 1'b1;
    issue(32'h00A60820);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ready", {31'd0, o_ready}, 32'd1);
    chk("mrst_busy", {31'd0, o_busy}, 32'd0);
    chk("mrst_ret", {16'd0, o_ret}, 32'd0);
    chk("mrst_done_we", {30'd0, o_done, o_we}, 32'd0);
    chk("mrst_zf", {31'd0, o_zf}, 32'd0);
    tick();
    chk("mrst_quiet", {30'd0, o_done, o_we}, 32'd0);
    tick();
    chk("mrst_quiet2", {30'd0, o_done, o_we}, 32'd0);
    trzf = 1'b0;

    // EXEC_CYCLES=3 build, valid held high: accepts every 6 edges.
    sel = 1;
    valid = 1'b1;
    instr = words[0];
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i % 6 == 0) begin
        if (i == 18) valid = 1'b0;
        else instr = words[i / 6 + 1];
      end
      chk($sformatf("b2b_done_%0d", i), {31'd0, o_done}, {31'd0, (i % 6 == 5)});
      chk($sformatf("b2b_ready_%0d", i), {31'd0, o_ready}, {31'd0, (i % 6 == 5)});
      chk($sformatf("b2b_busy_%0d", i), {31'd0, o_busy}, {31'd0, (i % 6 != 5)});
      if (i % 6 == 5) begin
        chk($sformatf("b2b_alu_%0d", i), {29'd0, o_alu}, {29'd0, ops[i / 6]});
        chk($sformatf("b2b_ret_%0d", i), {16'd0, o_ret}, i / 6 + 1);
      end
    end
    tick();
    chk("b2b_ret_final", {16'd0, o_ret}, 32'd4);
    chk("b2b_idle_ready", {31'd0, o_ready}, 32'd1);

    // CNT_W=2 build: counter saturates at 3.
    sel = 2;
    #0;
    for (int n = 1; n <= 5; n++) begin
      run_legal(32'h00A60820);
      chk($sformatf("sat_done_%0d", n), {31'd0, o_done}, 32'd1);
      chk($sformatf("sat_ret_%0d", n), {16'd0, o_ret}, (n > 3) ? 32'd3 : n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
